nx_fifo_wm: RTL

// - Parametrised synchronous FIFO: arbitrary (non-power-of-2) DEPTH, any WIDTH, first-word-fall-through read.
// - Programmable almost-full/almost-empty thresholds; peak-occupancy watermark with its own clear.
// - Registered underflow/overflow pulses.
// - General-purpose buffer for datapath staging and occupancy monitoring in the compression/crypto pipes.

---
 rtl/nx_fifo_wm.sv | 89 ++++++++
 1 files changed

// File: rtl/nx_fifo_wm.sv
// Synchronous first-word-fall-through FIFO for arbitrary DEPTH.
// Provides threshold flags, a peak-occupancy watermark and registered underflow/overflow pulses.
module nx_fifo_wm #(
    parameter int DEPTH      = 6,
    parameter int WIDTH      = 128,
    parameter bit DATA_RESET = 1'b1,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wen,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    input  logic [CW-1:0]    afull_thresh,
    input  logic [CW-1:0]    aempty_thresh,
    output logic             afull,
    output logic             aempty,
    output logic [CW-1:0]    used_slots,
    output logic [CW-1:0]    free_slots,
    output logic [CW-1:0]    max_used,
    input  logic             max_clr,
    output logic             underflow,
    output logic             overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rptr, wptr;
    logic [CW-1:0]    used, used_next;
    logic             wr_ok, rd_ok;

    // DEPTH need not be a power of two, so wrap by explicit compare.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty      = (used == '0);
    assign full       = (used == DEPTH_C);
    assign afull      = (used >= afull_thresh);
    assign aempty     = (used <= aempty_thresh);
    assign used_slots = used;
    assign free_slots = DEPTH_C - used;
    assign rdata      = (DATA_RESET && empty) ? '0 : mem[rptr];

    always_comb begin
        wr_ok     = wen & (~full | ren);
        rd_ok     = ren & ~empty;
        used_next = clear ? '0 : used + CW'(wr_ok) - CW'(rd_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr      <= '0;
            wptr      <= '0;
            used      <= '0;
            max_used  <= '0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            used <= used_next;
            if (max_clr)
                max_used <= used_next;
            else if (used_next > max_used)
                max_used <= used_next;
            if (clear) begin
                rptr      <= '0;
                wptr      <= '0;
                underflow <= 1'b0;
                overflow  <= 1'b0;
            end else begin
                if (wr_ok) wptr <= ptr_inc(wptr);
                if (rd_ok) rptr <= ptr_inc(rptr);
                overflow  <= wen & full & ~ren;
                underflow <= ren & empty;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && !clear && wr_ok)
            mem[wptr] <= wdata;
    end
endmodule
